mem_access: RTL



---
 rtl/mem_access.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the RV32IM pipeline.
// Passes non-memory results straight through to write-back. Runs loads and
// stores on a single-outstanding, ack-based data bus. Handles byte-lane
// steering, sign/zero extension of loads, misalignment detection and a bus
// timeout.
//
// State | Meaning
// IDLE  | no bus transaction; pass-through or capture a new memory op
// BUSY  | bus request held with captured values, waiting for ack or timeout
//
// Ports
//   clk_i, rst_i          clock, async active-low reset
//   reg_*_i               write-back fields from execute
//   mem_*_i               memory request from execute (mem_op_i decides the op)
//   bus_*_o / bus_*_i     data bus request, write data/enables, read data, ack
//   reg_*_o               registered write-back fields
//   stallreq_o            combinational stall request to the pipeline controller
//   misalign_o            one-cycle pulse for a misaligned access
//   bus_err_o             one-cycle pulse for a timed-out transaction
// Lane steering and extension assume DATA_WIDTH = 32.
module mem_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_op_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stallreq_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    // Encodings shared with the rest of the pipeline (defines.v).
    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [3:0]            cap_op;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [4:0]            cap_rd;
    logic                  cap_we;
    logic                  cap_is_load;

    logic                  is_mem;
    logic                  misaligned;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;

    logic                  nxt_reg_we;
    logic [4:0]            nxt_reg_waddr;
    logic [DATA_WIDTH-1:0] nxt_reg_wdata;
    logic                  nxt_misalign;
    logic                  nxt_bus_err;

    // mem_op_i alone decides the access type; the store flag is redundant.
    logic unused_mem_we;
    assign unused_mem_we = mem_we_i;

    always_comb begin
        is_mem     = 1'b0;
        misaligned = 1'b0;
        case (mem_op_i)
            MEM_LB, MEM_LBU, MEM_SB: is_mem = 1'b1;
            MEM_LH, MEM_LHU, MEM_SH: begin
                is_mem     = 1'b1;
                misaligned = mem_addr_i[0];
            end
            MEM_LW, MEM_SW: begin
                is_mem     = 1'b1;
                misaligned = |mem_addr_i[1:0];
            end
            default: ;
        endcase
    end

    assign cap_is_load = (cap_op != MEM_SB) && (cap_op != MEM_SH) && (cap_op != MEM_SW);

    always_comb begin
        case (cap_addr[1:0])
            2'd0:    ld_byte = bus_rdata_i[7:0];
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            default: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = cap_addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (cap_op)
            MEM_LB:  load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            MEM_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            MEM_LH:  load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            MEM_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_data = bus_rdata_i;
        endcase
    end

    // Bus outputs derive only from state and captured values, so they stay
    // stable for the whole transaction and drop as soon as reset hits.
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_be_o    = 4'b0000;
        if (state == S_BUSY) begin
            bus_req_o  = 1'b1;
            bus_addr_o = {cap_addr[ADDR_WIDTH-1:2], 2'b00};
            bus_be_o   = 4'b1111;
            case (cap_op)
                MEM_SB: begin
                    bus_we_o    = 1'b1;
                    bus_be_o    = 4'b0001 << cap_addr[1:0];
                    bus_wdata_o = {4{cap_data[7:0]}};
                end
                MEM_SH: begin
                    bus_we_o    = 1'b1;
                    bus_be_o    = cap_addr[1] ? 4'b1100 : 4'b0011;
                    bus_wdata_o = {2{cap_data[15:0]}};
                end
                MEM_SW: begin
                    bus_we_o    = 1'b1;
                    bus_wdata_o = cap_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        capture       = 1'b0;
        stallreq_o    = 1'b0;
        nxt_reg_we    = 1'b0;
        nxt_reg_waddr = '0;
        nxt_reg_wdata = '0;
        nxt_misalign  = 1'b0;
        nxt_bus_err   = 1'b0;
        if (state == S_IDLE) begin
            if (!is_mem) begin
                nxt_reg_we    = reg_we_i;
                nxt_reg_waddr = reg_waddr_i;
                nxt_reg_wdata = reg_wdata_i;
            end else if (misaligned) begin
                nxt_misalign = 1'b1;
            end else begin
                stallreq_o = 1'b1;
                capture    = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = S_BUSY;
            end
        end else begin
            // Ack wins over a timeout landing in the same cycle.
            if (bus_ack_i) begin
                state_nxt = S_IDLE;
                if (cap_is_load) begin
                    nxt_reg_we    = cap_we && (cap_rd != 5'd0);
                    nxt_reg_waddr = cap_rd;
                    nxt_reg_wdata = load_data;
                end
            end else if (cnt == CNT_LAST) begin
                state_nxt   = S_IDLE;
                nxt_bus_err = 1'b1;
            end else begin
                stallreq_o = 1'b1;
                cnt_nxt    = cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt         <= '0;
            cap_addr    <= '0;
            cap_op      <= MEM_NOP;
            cap_data    <= '0;
            cap_rd      <= '0;
            cap_we      <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (capture) begin
                cap_addr <= mem_addr_i;
                cap_op   <= mem_op_i;
                cap_data <= mem_data_i;
                cap_rd   <= reg_waddr_i;
                cap_we   <= reg_we_i;
            end
            reg_we_o    <= nxt_reg_we;
            reg_waddr_o <= nxt_reg_waddr;
            reg_wdata_o <= nxt_reg_wdata;
            misalign_o  <= nxt_misalign;
            bus_err_o   <= nxt_bus_err;
        end
    end

endmodule
